// File: rtl/alu_ctrl_issue.sv
// ALU control decode plus ID/EX valid/ready issue register.
// Decodes opcode/funct into ALUFun/Sign, flags undecodable instructions
// and keeps a saturating count of accepted illegal instructions.
module alu_ctrl_issue (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] ALUFun,
  output logic       Sign,
  output logic       illegal,
  output logic [7:0] illegal_cnt
);

  localparam logic [5:0] FunAdd = 6'b000000;
  localparam logic [5:0] FunSub = 6'b000001;
  localparam logic [5:0] FunAnd = 6'b011000;
  localparam logic [5:0] FunOr  = 6'b011110;
  localparam logic [5:0] FunXor = 6'b010110;
  localparam logic [5:0] FunNor = 6'b010001;
  localparam logic [5:0] FunA   = 6'b011010;
  localparam logic [5:0] FunSll = 6'b100000;
  localparam logic [5:0] FunSrl = 6'b100001;
  localparam logic [5:0] FunSra = 6'b100011;
  localparam logic [5:0] FunEq  = 6'b110011;
  localparam logic [5:0] FunNeq = 6'b110001;
  localparam logic [5:0] FunLt  = 6'b110101;
  localparam logic [5:0] FunLez = 6'b111101;
  localparam logic [5:0] FunLtz = 6'b111011;
  localparam logic [5:0] FunGtz = 6'b111111;

  logic [5:0] dec_fun;
  logic       dec_sign;
  logic       dec_ill;
  logic       accept;
  logic       take;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  // An accept killed by a same-cycle flush must leave no trace.
  assign take     = accept & ~flush;

  // Decode opcode/funct; illegal encodings fall back to ADD, unsigned.
  always_comb begin
    dec_fun  = FunAdd;
    dec_sign = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_fun = FunAdd; dec_sign = 1'b1; end
          6'h21: dec_fun = FunAdd;
          6'h22: begin dec_fun = FunSub; dec_sign = 1'b1; end
          6'h23: dec_fun = FunSub;
          6'h24: dec_fun = FunAnd;
          6'h25: dec_fun = FunOr;
          6'h26: dec_fun = FunXor;
          6'h27: dec_fun = FunNor;
          6'h2A: begin dec_fun = FunLt; dec_sign = 1'b1; end
          6'h2B: dec_fun = FunLt;
          6'h00: dec_fun = FunSll;
          6'h02: dec_fun = FunSrl;
          6'h03: dec_fun = FunSra;
          6'h08, 6'h09: dec_fun = FunAdd;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08: begin dec_fun = FunAdd; dec_sign = 1'b1; end
      6'h09: dec_fun = FunAdd;
      6'h0C: dec_fun = FunAnd;
      6'h0D: dec_fun = FunOr;
      6'h0A: begin dec_fun = FunLt; dec_sign = 1'b1; end
      6'h0B: dec_fun = FunLt;
      6'h0F: dec_fun = FunA;
      6'h23, 6'h2B: dec_fun = FunAdd;
      6'h04: begin dec_fun = FunEq;  dec_sign = 1'b1; end
      6'h05: begin dec_fun = FunNeq; dec_sign = 1'b1; end
      6'h06: begin dec_fun = FunLez; dec_sign = 1'b1; end
      6'h07: begin dec_fun = FunGtz; dec_sign = 1'b1; end
      6'h01: begin dec_fun = FunLtz; dec_sign = 1'b1; end
      6'h02, 6'h03: dec_fun = FunAdd;
      default: dec_ill = 1'b1;
    endcase
  end

  // Valid flag: flush beats load, load beats drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Data register loads only on a surviving accept, so it is stable under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUFun  <= FunAdd;
      Sign    <= 1'b0;
      illegal <= 1'b0;
    end else if (take) begin
      ALUFun  <= dec_fun;
      Sign    <= dec_sign;
      illegal <= dec_ill;
    end
  end

  // Saturating illegal-instruction counter, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt <= 8'd0;
    end else if (take && dec_ill && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: directed test-plan sequences with
// literal expectations plus a randomized run against a behavioural model.
module tb_alu_ctrl_issue;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] ALUFun;
  logic       Sign;
  logic       illegal;
  logic [7:0] illegal_cnt;

  int n_checks = 0;
  int n_fail = 0;

  alu_ctrl_issue dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct      (funct),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUFun     (ALUFun),
    .Sign       (Sign),
    .illegal    (illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Reference decode table: returns {illegal, sign, alufun}.
  function automatic logic [7:0] ref_dec(input logic [5:0] op, input logic [5:0] fn);
    logic [7:0] r;
    r = {2'b10, 6'b000000};
    if (op == 6'h00) begin
      case (fn)
        6'h20: r = {2'b01, 6'b000000};
        6'h21: r = {2'b00, 6'b000000};
        6'h22: r = {2'b01, 6'b000001};
        6'h23: r = {2'b00, 6'b000001};
        6'h24: r = {2'b00, 6'b011000};
        6'h25: r = {2'b00, 6'b011110};
        6'h26: r = {2'b00, 6'b010110};
        6'h27: r = {2'b00, 6'b010001};
        6'h2A: r = {2'b01, 6'b110101};
        6'h2B: r = {2'b00, 6'b110101};
        6'h00: r = {2'b00, 6'b100000};
        6'h02: r = {2'b00, 6'b100001};
        6'h03: r = {2'b00, 6'b100011};
        6'h08: r = {2'b00, 6'b000000};
        6'h09: r = {2'b00, 6'b000000};
        default: r = {2'b10, 6'b000000};
      endcase
    end else begin
      case (op)
        6'h08: r = {2'b01, 6'b000000};
        6'h09: r = {2'b00, 6'b000000};
        6'h0C: r = {2'b00, 6'b011000};
        6'h0D: r = {2'b00, 6'b011110};
        6'h0A: r = {2'b01, 6'b110101};
        6'h0B: r = {2'b00, 6'b110101};
        6'h0F: r = {2'b00, 6'b011010};
        6'h23: r = {2'b00, 6'b000000};
        6'h2B: r = {2'b00, 6'b000000};
        6'h04: r = {2'b01, 6'b110011};
        6'h05: r = {2'b01, 6'b110001};
        6'h06: r = {2'b01, 6'b111101};
        6'h07: r = {2'b01, 6'b111111};
        6'h01: r = {2'b01, 6'b111011};
        6'h02: r = {2'b00, 6'b000000};
        6'h03: r = {2'b00, 6'b000000};
        default: r = {2'b10, 6'b000000};
      endcase
    end
    return r;
  endfunction

  // Behavioural model of the issue slot.
  logic       m_valid = 1'b0;
  logic [7:0] m_ent = 8'h00;
  int         m_cnt = 0;
  logic       m_accept;
  logic [7:0] m_dec;

  assign m_accept = in_valid && (!m_valid || out_ready);
  assign m_dec    = ref_dec(opcode, funct);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_ent   <= 8'h00;
      m_cnt   <= 0;
    end else begin
      if (flush) m_valid <= 1'b0;
      else if (m_accept) m_valid <= 1'b1;
      else if (out_ready) m_valid <= 1'b0;
      if (m_accept && !flush) begin
        m_ent <= m_dec;
        if (m_dec[7] && m_cnt < 255) m_cnt <= m_cnt + 1;
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    if (m_valid) begin
      chk("ALUFun", 32'(ALUFun), 32'(m_ent[5:0]));
      chk("Sign", 32'(Sign), 32'(m_ent[6]));
      chk("illegal", 32'(illegal), 32'(m_ent[7]));
    end
  end

  task automatic cyc(input logic iv, input logic [5:0] op, input logic [5:0] fn,
                     input logic ordy, input logic fl);
    in_valid  = iv;
    opcode    = op;
    funct     = fn;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [5:0] legal_ops [17] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02,
                                 6'h03};
  logic [5:0] legal_fns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst ALUFun", 32'(ALUFun), 32'd0);
    chk("rst Sign", 32'(Sign), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst cnt", 32'(illegal_cnt), 32'd0);
    reset = 1'b0;

    // sub
    cyc(1'b1, 6'h00, 6'h22, 1'b1, 1'b0);
    chk("sub valid", 32'(out_valid), 32'd1);
    chk("sub fun", 32'(ALUFun), 32'b000001);
    chk("sub sign", 32'(Sign), 32'd1);
    chk("sub illegal", 32'(illegal), 32'd0);

    // Back-to-back stream with no bubbles.
    cyc(1'b1, 6'h0D, 6'h00, 1'b1, 1'b0);
    chk("ori fun", 32'(ALUFun), 32'b011110);
    cyc(1'b1, 6'h00, 6'h03, 1'b1, 1'b0);
    chk("sra fun", 32'(ALUFun), 32'b100011);
    cyc(1'b1, 6'h0B, 6'h00, 1'b1, 1'b0);
    chk("sltiu fun", 32'(ALUFun), 32'b110101);
    chk("sltiu sign", 32'(Sign), 32'd0);
    cyc(1'b1, 6'h01, 6'h00, 1'b1, 1'b0);
    chk("bltz fun", 32'(ALUFun), 32'b111011);
    chk("bltz sign", 32'(Sign), 32'd1);
    chk("bltz valid", 32'(out_valid), 32'd1);

    // Backpressure: beq held while ori waits.
    cyc(1'b1, 6'h04, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      opcode    = 6'h0D;
      out_ready = 1'b0;
      #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("stall fun", 32'(ALUFun), 32'b110011);
      chk("stall valid", 32'(out_valid), 32'd1);
    end
    cyc(1'b1, 6'h0D, 6'h00, 1'b1, 1'b0);
    chk("drain fun", 32'(ALUFun), 32'b011110);

    // Flush of an accepting entry, then of a held entry.
    cyc(1'b1, 6'h23, 6'h00, 1'b1, 1'b1);
    chk("flush accept", 32'(out_valid), 32'd0);
    cyc(1'b1, 6'h08, 6'h00, 1'b0, 1'b0);
    chk("addi valid", 32'(out_valid), 32'd1);
    cyc(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
    chk("flush held", 32'(out_valid), 32'd0);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      int oi;
      int fi;
      oi = int'($urandom_range(0, 16));
      fi = int'($urandom_range(0, 14));
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 1) != 0) ? legal_ops[oi] : 6'($urandom),
          ($urandom_range(0, 1) != 0) ? legal_fns[fi] : 6'($urandom),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0);
    end

    // Illegal reporting and saturation from a clean counter.
    pulse_reset();
    cyc(1'b1, 6'h3F, 6'h00, 1'b1, 1'b0);
    chk("ill op flag", 32'(illegal), 32'd1);
    chk("ill op fun", 32'(ALUFun), 32'd0);
    chk("ill op sign", 32'(Sign), 32'd0);
    chk("ill op cnt", 32'(illegal_cnt), 32'd1);
    cyc(1'b1, 6'h00, 6'h3F, 1'b1, 1'b0);
    chk("ill fn flag", 32'(illegal), 32'd1);
    chk("ill fn cnt", 32'(illegal_cnt), 32'd2);
    cyc(1'b1, 6'h3F, 6'h00, 1'b1, 1'b1);
    chk("ill flushed cnt", 32'(illegal_cnt), 32'd2);
    repeat (260) cyc(1'b1, 6'h3F, 6'h00, 1'b1, 1'b0);
    chk("ill sat cnt", 32'(illegal_cnt), 32'd255);

    // Asynchronous reset mid-stall.
    cyc(1'b1, 6'h04, 6'h00, 1'b1, 1'b0);
    cyc(1'b1, 6'h05, 6'h00, 1'b0, 1'b0);
    chk("pre-areset valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset valid", 32'(out_valid), 32'd0);
    chk("areset cnt", 32'(illegal_cnt), 32'd0);
    chk("areset in_ready", 32'(in_ready), 32'd1);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 6'h00, 6'h2A, 1'b1, 1'b0);
    chk("post-reset fun", 32'(ALUFun), 32'b110101);
    chk("post-reset sign", 32'(Sign), 32'd1);
    cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_issue.md
# alu_ctrl_issue

Decode-and-issue stage for the pipelined CPU's ALU. It takes instruction opcode/funct fields from ID and decodes them into the 6-bit ALUFun and Sign controls consumed by the EX-stage ALU sub-units (add/sub, logic, shift, compare). It holds the result in a valid/ready pipeline register at the ID/EX boundary, with flush support and illegal-instruction reporting.

## Interface
- No parameters; all widths fixed.
- clk  in  1  clock, all state rises on posedge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage can accept this cycle
- opcode  in  6  Instruction[31:26]
- funct  in  6  Instruction[5:0]
- flush  in  1  kill the held entry and any entry being accepted
- out_valid  out  1  ALUFun/Sign valid toward EX
- out_ready  in  1  EX consumes this cycle
- ALUFun  out  6  ALU operation code
- Sign  out  1  1 = signed compare/overflow semantics
- illegal  out  1  held entry had an undecodable opcode/funct
- illegal_cnt  out  8  saturating count of accepted illegal instructions

## Operation
- ALUFun encodings:
  - ADD 000000, SUB 000001
  - AND 011000, OR 011110, XOR 010110, NOR 010001, A 011010
  - SLL 100000, SRL 100001, SRA 100011
  - EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111
- R-type (opcode 0x00), funct:
  - 0x20 ADD/S1, 0x21 ADD/S0, 0x22 SUB/S1, 0x23 SUB/S0
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x2A LT/S1, 0x2B LT/S0
  - 0x00 SLL, 0x02 SRL, 0x03 SRA
  - 0x08 jr and 0x09 jalr → ADD/S0
  - Any other funct is illegal.
- Other opcodes:
  - 0x08 ADD/S1, 0x09 ADD/S0
  - 0x0C AND, 0x0D OR
  - 0x0A LT/S1, 0x0B LT/S0
  - 0x0F lui → A
  - 0x23 lw and 0x2B sw → ADD/S0
  - 0x04 EQ, 0x05 NEQ, 0x06 LEZ, 0x07 GTZ, 0x01 LTZ (all S1)
  - 0x02 j and 0x03 jal → ADD/S0
  - Any other opcode is illegal.
- Sign = 0 for logic and shift ops.
- Illegal decode: ALUFun=ADD, Sign=0, illegal=1.
- Accept: a transfer in occurs when in_valid & in_ready. The decoded result is loaded into the register with out_valid=1.
- in_ready = ~out_valid | out_ready (combinational). It is independent of flush.
- Transfer out: out_valid & out_ready.
- With no transfer out and no accept, the register holds. ALUFun, Sign, and illegal stay stable while out_valid=1 and out_ready=0.
- flush: next cycle out_valid=0, and an entry accepted in the same cycle is discarded. Flush has priority over load.
- illegal_cnt:
  - Increments by 1 on each accepted illegal instruction not killed by a same-cycle flush.
  - Saturates at 255 with no wrap.
  - Cleared only by reset.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Full throughput: one instruction per cycle while out_ready=1.
- On reset, asynchronously and immediately:
  - out_valid=0, ALUFun=000000, Sign=0, illegal=0, illegal_cnt=0
  - in_ready therefore reads 1.
- Reset mid-operation discards the held entry. The first posedge after reset deassertion may accept.
- Data registers (ALUFun, Sign, illegal) load only on accept. When out_valid=0 their value is don't-care to EX, but is never X after reset.
- Simultaneous events:
  - Transfer out plus accept: the register replaces, out_valid stays 1.
  - Flush plus accept: out_valid=0 next cycle and the counter is not incremented.
  - Flush plus transfer out: EX still sees that cycle's transfer, then out_valid=0.

## Test plan
- Reset, then in_valid=1, opcode=0x00, funct=0x22, out_ready=1 → next cycle out_valid=1, ALUFun=000001, Sign=1, illegal=0.
- Back-to-back stream, out_ready=1: ori (0x0D), sra (R/0x03), sltiu (0x0B), bltz (0x01) → ALUFun 011110, 100011, 110101 (Sign=0), 111011 (Sign=1) on consecutive cycles with no bubbles.
- Backpressure: load beq (0x04), hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, ALUFun=110011 stable. out_ready=1 → the next queued instruction appears one cycle later.
- Flush: accept lw (0x23) with flush=1 in the same cycle → out_valid=0 next cycle. Flush while holding a valid entry → out_valid drops the next cycle.
- Illegal: opcode=0x3F, then R-type funct=0x3F → illegal=1, ALUFun=000000, illegal_cnt=2. Then 260 illegal accepts → illegal_cnt=255.
- Assert reset asynchronously mid-stall with out_valid=1 → out_valid=0, illegal_cnt=0 before the next clock edge.
